mem_writeback_unit: RTL

Memory-access and writeback stage that sits directly upstream of the register file's write port. It accepts one instruction at a time from execute. It performs the data-memory load or store over a req/ack handshake, aligning bytes and halfwords, and sign- or zero-extending loaded data. It then drives the register file's write enable, index and data for a single cycle.

---
 rtl/mem_writeback_unit_if.sv | 55 +++++
 rtl/mem_writeback_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_writeback_unit_if
// Purpose  : Execute / data-memory / register-file bundle for mem_writeback_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_writeback_unit_if #(
    parameter int ADDR_W = 32
);
    // Execute side
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_is_load;
    logic              ex_is_store;
    logic              ex_reg_write;
    logic [2:0]        ex_funct3;
    logic [ADDR_W-1:0] ex_addr;
    logic [31:0]       ex_store_data;
    logic [31:0]       ex_alu_result;
    logic [4:0]        ex_rd;

    // Data-memory side
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_be;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ack;

    // Register-file side and status
    logic              rf_write;
    logic [4:0]        rf_index;
    logic [31:0]       rf_data;
    logic              access_fault;

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_reg_write, ex_funct3,
               ex_addr, ex_store_data, ex_alu_result, ex_rd,
               dm_rdata, dm_ack,
        output ex_ready,
               dm_req, dm_we, dm_addr, dm_be, dm_wdata,
               rf_write, rf_index, rf_data, access_fault
    );

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_reg_write, ex_funct3,
               ex_addr, ex_store_data, ex_alu_result, ex_rd,
               dm_rdata, dm_ack,
        input  ex_ready,
               dm_req, dm_we, dm_addr, dm_be, dm_wdata,
               rf_write, rf_index, rf_data, access_fault
    );
endinterface
`default_nettype wire

// File: rtl/mem_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_writeback_unit
// Purpose  : Memory-access + writeback stage: aligned load/store over req/ack,
//            load extension, single-cycle register-file write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_writeback_unit #(
    parameter int ADDR_W = 32
) (
    input wire                    CLK,
    input wire                    RST,
    mem_writeback_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WB       = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_fault;
    logic               r_dm_req;
    logic               r_dm_we;
    logic [ADDR_W-1:0]  r_dm_addr;
    logic [3:0]         r_dm_be;
    logic [31:0]        r_dm_wdata;
    logic               r_is_load;
    logic [2:0]         r_funct3;
    logic [1:0]         r_lane;
    logic [4:0]         r_rd;
    logic               r_rf_write;
    logic [4:0]         r_rf_index;
    logic [31:0]        r_rf_data;

    logic               w_accept;
    logic               w_is_mem;
    logic               w_is_half;
    logic               w_is_word;
    logic               w_load_f3_ok;
    logic               w_store_f3_ok;
    logic               w_misaligned;
    logic               w_fault;
    logic               w_rd_nz;
    logic [3:0]         w_st_be;
    logic [31:0]        w_st_wdata;
    logic [7:0]         w_ld_byte;
    logic [15:0]        w_ld_half;
    logic [31:0]        w_ld_data;

    // ------------------------------------------------------------------
    // Acceptance and fault decode
    // ------------------------------------------------------------------
    assign w_accept  = bus.ex_valid && (r_state == IDLE);
    assign w_is_mem  = bus.ex_is_load || bus.ex_is_store;
    assign w_is_half = (bus.ex_funct3[1:0] == 2'b01);
    assign w_is_word = (bus.ex_funct3[1:0] == 2'b10);
    assign w_rd_nz   = (bus.ex_rd != 5'd0);

    assign w_load_f3_ok  = (bus.ex_funct3 == 3'b000) || (bus.ex_funct3 == 3'b001) ||
                           (bus.ex_funct3 == 3'b010) || (bus.ex_funct3 == 3'b100) ||
                           (bus.ex_funct3 == 3'b101);
    assign w_store_f3_ok = (bus.ex_funct3 == 3'b000) || (bus.ex_funct3 == 3'b001) ||
                           (bus.ex_funct3 == 3'b010);

    assign w_misaligned = (w_is_half && bus.ex_addr[0]) ||
                          (w_is_word && (bus.ex_addr[1:0] != 2'b00));

    assign w_fault = w_is_mem &&
                     ((bus.ex_is_load && bus.ex_is_store) ||
                      (bus.ex_is_load  && !w_store_f3_ok && !w_load_f3_ok) ||
                      (bus.ex_is_load  && !w_load_f3_ok) ||
                      (bus.ex_is_store && !w_store_f3_ok) ||
                      w_misaligned);

    // Lane mask and replicated data; loads reuse the mask to flag the lanes read
    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = bus.ex_store_data;
        case (bus.ex_funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << bus.ex_addr[1:0];
                w_st_wdata = {4{bus.ex_store_data[7:0]}};
            end
            2'b01: begin
                w_st_be    = bus.ex_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{bus.ex_store_data[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = bus.ex_store_data;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_byte = bus.dm_rdata[7:0];
        case (r_lane)
            2'd0:    w_ld_byte = bus.dm_rdata[7:0];
            2'd1:    w_ld_byte = bus.dm_rdata[15:8];
            2'd2:    w_ld_byte = bus.dm_rdata[23:16];
            default: w_ld_byte = bus.dm_rdata[31:24];
        endcase
    end

    assign w_ld_half = r_lane[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

    always_comb begin
        w_ld_data = bus.dm_rdata;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = bus.dm_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_fault    <= 1'b0;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_be    <= 4'd0;
            r_dm_wdata <= 32'd0;
            r_is_load  <= 1'b0;
            r_funct3   <= 3'd0;
            r_lane     <= 2'd0;
            r_rd       <= 5'd0;
            r_rf_write <= 1'b0;
            r_rf_index <= 5'd0;
            r_rf_data  <= 32'd0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem) begin
                            r_state    <= WB;
                            r_rf_write <= bus.ex_reg_write && w_rd_nz;
                            r_rf_index <= (bus.ex_reg_write && w_rd_nz) ? bus.ex_rd : 5'd0;
                            r_rf_data  <= (bus.ex_reg_write && w_rd_nz) ? bus.ex_alu_result : 32'd0;
                        end else if (w_fault) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_state    <= MEM_WAIT;
                            r_dm_req   <= 1'b1;
                            r_dm_we    <= bus.ex_is_store;
                            r_dm_addr  <= {bus.ex_addr[ADDR_W-1:2], 2'b00};
                            r_dm_be    <= w_st_be;
                            r_dm_wdata <= bus.ex_is_store ? w_st_wdata : 32'd0;
                            r_is_load  <= bus.ex_is_load;
                            r_funct3   <= bus.ex_funct3;
                            r_lane     <= bus.ex_addr[1:0];
                            r_rd       <= bus.ex_rd;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (bus.dm_ack) begin
                        r_dm_req   <= 1'b0;
                        r_dm_we    <= 1'b0;
                        r_dm_addr  <= '0;
                        r_dm_be    <= 4'd0;
                        r_dm_wdata <= 32'd0;
                        if (r_is_load) begin
                            r_state    <= WB;
                            r_rf_write <= (r_rd != 5'd0);
                            r_rf_index <= r_rd;
                            r_rf_data  <= (r_rd != 5'd0) ? w_ld_data : 32'd0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                WB: begin
                    r_state    <= IDLE;
                    r_rf_write <= 1'b0;
                    r_rf_index <= 5'd0;
                    r_rf_data  <= 32'd0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ex_ready     = (r_state == IDLE);
    assign bus.dm_req       = r_dm_req;
    assign bus.dm_we        = r_dm_we;
    assign bus.dm_addr      = r_dm_addr;
    assign bus.dm_be        = r_dm_be;
    assign bus.dm_wdata     = r_dm_wdata;
    assign bus.rf_write     = r_rf_write;
    assign bus.rf_index     = r_rf_index;
    assign bus.rf_data      = r_rf_data;
    assign bus.access_fault = r_fault;

endmodule
`default_nettype wire
